// File: rtl/imem_loader_pkg.sv
// Shared processor package: loader FSM states and default instruction-memory geometry.
package imem_loader_pkg;
  localparam int IMEM_ADDR_W = 9;
  localparam int IMEM_DEPTH  = 512;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } loader_state_t;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles four bytes into a 32-bit little-endian word; byte 0 lands in [7:0].
module byte_packer (
  input  logic        clk1,
  input  logic        reset1,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);
  logic [1:0] byte_cnt;

  always_ff @(posedge clk1 or posedge reset1) begin
    if (reset1) begin
      byte_cnt <= '0;
      word     <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      word     <= '0;
    end else if (accept) begin
      word[{byte_cnt, 3'b000} +: 8] <= byte_in;
      byte_cnt                      <= byte_cnt + 2'd1;
    end
  end

  // High in the cycle the fourth byte of a word is being accepted.
  assign word_full = accept && (byte_cnt == 2'd3);
endmodule

// File: rtl/imem_loader.sv
// Streams program bytes into instruction memory one word at a time while holding the CPU in reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input  logic              clk1,
  input  logic              reset1,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_wr_addr,
  output logic [31:0]       imem_wr_data,
  output logic              cpu_reset_hold,
  output logic              busy,
  output logic              load_done,
  output logic              load_err,
  output loader_state_t     fsm_state
);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  loader_state_t   state_q, state_d;
  logic [ADDR_W:0] word_cnt, word_nxt, len_q;
  logic            idle_like, start_ok, start_zero, start_big;
  logic            accept, word_full, last_word;
  logic [31:0]     word;

  assign idle_like  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign start_ok   = idle_like && load_start && (load_len != '0) && (load_len <= DEPTH_C);
  assign start_zero = idle_like && load_start && (load_len == '0);
  assign start_big  = idle_like && load_start && (load_len > DEPTH_C);
  // Byte handshake: a byte transfers on a rising edge where byte_valid and byte_ready are both high;
  // byte_ready depends only on state, so the source may hold byte_valid through WRITE cycles.
  assign accept     = byte_valid && byte_ready;
  assign word_nxt   = word_cnt + (ADDR_W + 1)'(1);
  assign last_word  = (state_q == ST_WRITE) && (word_nxt == len_q);

  byte_packer u_packer (
    .clk1      (clk1),
    .reset1    (reset1),
    .clear     (start_ok),
    .accept    (accept),
    .byte_in   (byte_in),
    .word      (word),
    .word_full (word_full)
  );

  always_ff @(posedge clk1 or posedge reset1) begin
    if (reset1) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok)                     state_d = ST_COLLECT;
        else if (start_zero || start_big) state_d = ST_DONE;
      end
      ST_COLLECT: if (word_full) state_d = ST_WRITE;
      ST_WRITE:   state_d = last_word ? ST_DONE : ST_COLLECT;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk1 or posedge reset1) begin
    if (reset1) begin
      word_cnt       <= '0;
      len_q          <= '0;
      load_done      <= 1'b0;
      load_err       <= 1'b0;
      cpu_reset_hold <= 1'b1;
    end else begin
      load_done <= start_zero || start_big || last_word;
      if (start_ok) begin
        word_cnt       <= '0;
        len_q          <= load_len;
        load_err       <= 1'b0;
        cpu_reset_hold <= 1'b1;
      end else if (start_zero) begin
        load_err <= 1'b0;
      end else if (start_big) begin
        load_err       <= 1'b1;
        cpu_reset_hold <= 1'b1;
      end
      if (state_q == ST_WRITE) word_cnt <= word_nxt;
      if (last_word)           cpu_reset_hold <= 1'b0;
    end
  end

  assign byte_ready   = (state_q == ST_COLLECT);
  assign imem_wr_en   = (state_q == ST_WRITE);
  assign busy         = (state_q == ST_COLLECT) || (state_q == ST_WRITE);
  // Address is forced to zero outside WRITE so the counter's terminal value never shows.
  assign imem_wr_addr = imem_wr_en ? word_cnt[ADDR_W-1:0] : '0;
  assign imem_wr_data = word;
  assign fsm_state    = state_q;
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus randomized loads against a word-list model.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;
  localparam int W      = ADDR_W + 32;

  logic              clk1 = 1'b0;
  logic              reset1 = 1'b1;
  logic              load_start = 1'b0;
  logic [ADDR_W:0]   load_len = '0;
  logic [7:0]        byte_in = '0;
  logic              byte_valid = 1'b0;
  logic              byte_ready, imem_wr_en, cpu_reset_hold, busy, load_done, load_err;
  logic [ADDR_W-1:0] imem_wr_addr;
  logic [31:0]       imem_wr_data;
  loader_state_t     fsm_state;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk1           (clk1),
    .reset1         (reset1),
    .load_start     (load_start),
    .load_len       (load_len),
    .byte_in        (byte_in),
    .byte_valid     (byte_valid),
    .byte_ready     (byte_ready),
    .imem_wr_en     (imem_wr_en),
    .imem_wr_addr   (imem_wr_addr),
    .imem_wr_data   (imem_wr_data),
    .cpu_reset_hold (cpu_reset_hold),
    .busy           (busy),
    .load_done      (load_done),
    .load_err       (load_err),
    .fsm_state      (fsm_state)
  );

  // Clock / reset
  always #5 clk1 = ~clk1;

  int checks = 0;
  int fails  = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, wr_cyc = 0, acc_cyc = 0, rdy_viol = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  logic [7:0]   stim_q[$];

  // Monitor: observes outputs at the falling edge, well away from the active edge.
  always @(negedge clk1) begin
    cyc <= cyc + 1;
    if (imem_wr_en) begin
      obs_q.push_back({imem_wr_addr, imem_wr_data});
      wr_cyc <= cyc;
    end
    if (imem_wr_en && byte_ready) rdy_viol <= rdy_viol + 1;
    if (load_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (byte_valid && byte_ready) acc_cyc <= cyc;
  end

  // Driver tasks
  task automatic tick();
    @(negedge clk1);
    #1;
  endtask

  task automatic start_load(input int len);
    load_start = 1'b1;
    load_len   = len[ADDR_W:0];
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    if (gap) tick();
    byte_in    = b;
    byte_valid = 1'b1;
    n = 0;
    while (byte_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      fails++;
      $display("FAIL byte_accept_timeout: byte_ready never high, required 1");
    end
    tick();
    byte_valid = 1'b0;
  endtask

  // mode 0: back-to-back, 1: gap before every byte, 2: random gaps
  task automatic send_stream(input int first, input int count, input int mode);
    for (int i = first; i < first + count; i++) begin
      send_byte(stim_q[i], (mode == 1) || (mode == 2 && $urandom_range(0, 1) == 1));
    end
  endtask

  task automatic wait_done(input int base, input int bound);
    int n;
    n = 0;
    while (done_cnt == base && n < bound) begin
      tick();
      n++;
    end
    if (done_cnt == base) begin
      checks++;
      fails++;
      $display("FAIL load_done_timeout: no load_done within %0d cycles", bound);
    end
    repeat (3) tick();
  endtask

  // Reference model: word k is bytes 4k..4k+3, little-endian, written at address k.
  task automatic model_load(input int nwords);
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
    exp_q.delete();
    for (int k = 0; k < nwords; k++) begin
      a = k[ADDR_W-1:0];
      d = stim_q[4*k] | (32'(stim_q[4*k+1]) << 8) | (32'(stim_q[4*k+2]) << 16)
        | (32'(stim_q[4*k+3]) << 24);
      exp_q.push_back({a, d});
    end
  endtask

  task automatic random_stim(input int nbytes);
    stim_q.delete();
    for (int i = 0; i < nbytes; i++) stim_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic test_reset();
    reset1 = 1'b1;
    tick();
    tick();
    checks++;
    if ({byte_ready, imem_wr_en, busy, load_done, load_err, cpu_reset_hold} !== 6'b000001) begin
      fails++;
      $display("FAIL reset_flags: got %b required 000001",
               {byte_ready, imem_wr_en, busy, load_done, load_err, cpu_reset_hold});
    end
    checks++;
    if ({imem_wr_addr, imem_wr_data} !== '0) begin
      fails++;
      $display("FAIL reset_addr_data: got %h/%h required 0/0", imem_wr_addr, imem_wr_data);
    end
    checks++;
    if (fsm_state !== ST_IDLE) begin
      fails++;
      $display("FAIL reset_state: got %0d required %0d", fsm_state, ST_IDLE);
    end
    reset1 = 1'b0;
    tick();
  endtask

  task automatic test_vector();
    int base;
    stim_q = '{8'hb3, 8'h82, 8'h41, 8'h00, 8'h33, 8'h83, 8'h41, 8'h40};
    model_load(2);
    obs_q.delete();
    base = done_cnt;
    start_load(2);
    send_stream(0, 8, 0);
    wait_done(base, 20);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL vector_count: got %0d writes required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL vector_write[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_cnt - base !== 1) begin
      fails++;
      $display("FAIL vector_done_pulses: got %0d required 1", done_cnt - base);
    end
    checks++;
    if ({cpu_reset_hold, busy, load_err} !== 3'b000) begin
      fails++;
      $display("FAIL vector_final_flags: got %b required 000", {cpu_reset_hold, busy, load_err});
    end
    checks++;
    if (wr_cyc - acc_cyc !== 1 || done_cyc - acc_cyc !== 2) begin
      fails++;
      $display("FAIL vector_latency: got wr +%0d done +%0d required +1 +2",
               wr_cyc - acc_cyc, done_cyc - acc_cyc);
    end
  endtask

  task automatic test_gaps();
    int base, viol;
    stim_q = '{8'hb3, 8'h82, 8'h41, 8'h00, 8'h33, 8'h83, 8'h41, 8'h40};
    model_load(2);
    obs_q.delete();
    base = done_cnt;
    viol = rdy_viol;
    start_load(2);
    send_stream(0, 8, 1);
    wait_done(base, 20);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL gaps_count: got %0d writes required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL gaps_write[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (rdy_viol - viol !== 0) begin
      fails++;
      $display("FAIL gaps_ready_in_write: got %0d cycles required 0", rdy_viol - viol);
    end
    checks++;
    if (load_err !== 1'b0) begin
      fails++;
      $display("FAIL gaps_err_cleared: got %b required 0", load_err);
    end
  endtask

  task automatic test_zero_len();
    int base;
    obs_q.delete();
    base = done_cnt;
    start_load(0);
    repeat (3) tick();
    checks++;
    if (obs_q.size() !== 0 || done_cnt - base !== 1) begin
      fails++;
      $display("FAIL zero_len: got %0d writes %0d dones required 0 1", obs_q.size(), done_cnt - base);
    end
    checks++;
    if ({load_err, busy} !== 2'b00) begin
      fails++;
      $display("FAIL zero_len_flags: got %b required 00", {load_err, busy});
    end
  endtask

  task automatic test_too_long();
    int base;
    obs_q.delete();
    base = done_cnt;
    start_load(DEPTH + 1);
    repeat (3) tick();
    checks++;
    if (obs_q.size() !== 0 || done_cnt - base !== 1) begin
      fails++;
      $display("FAIL too_long: got %0d writes %0d dones required 0 1", obs_q.size(), done_cnt - base);
    end
    checks++;
    if ({load_err, cpu_reset_hold, busy} !== 3'b110) begin
      fails++;
      $display("FAIL too_long_flags: got %b required 110", {load_err, cpu_reset_hold, busy});
    end
  endtask

  task automatic test_ignore_start();
    int base;
    random_stim(8);
    model_load(2);
    obs_q.delete();
    base = done_cnt;
    start_load(2);
    send_stream(0, 4, 0);
    start_load(5);
    send_stream(4, 2, 0);
    start_load(5);
    send_stream(6, 2, 0);
    wait_done(base, 20);
    checks++;
    if (obs_q.size() !== exp_q.size() || done_cnt - base !== 1) begin
      fails++;
      $display("FAIL ignore_start: got %0d writes %0d dones required %0d 1",
               obs_q.size(), done_cnt - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL ignore_start_write[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    random_stim(8);
    model_load(2);
    obs_q.delete();
    start_load(2);
    send_stream(0, 6, 0);
    reset1 = 1'b1;
    #1;
    checks++;
    if ({byte_ready, imem_wr_en, busy, load_done, load_err, cpu_reset_hold} !== 6'b000001
        || {imem_wr_addr, imem_wr_data} !== '0) begin
      fails++;
      $display("FAIL reset_mid_outputs: got %b %h %h required 000001 0 0",
               {byte_ready, imem_wr_en, busy, load_done, load_err, cpu_reset_hold},
               imem_wr_addr, imem_wr_data);
    end
    tick();
    reset1 = 1'b0;
    tick();
    checks++;
    if (obs_q.size() !== 1) begin
      fails++;
      $display("FAIL reset_mid_count: got %0d writes required 1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0] !== exp_q[0]) begin
        fails++;
        $display("FAIL reset_mid_write: got %h required %h", obs_q[0], exp_q[0]);
      end
    end
    random_stim(4);
    model_load(1);
    obs_q.delete();
    base = done_cnt;
    start_load(1);
    send_stream(0, 4, 0);
    wait_done(base, 20);
    checks++;
    if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0] || cpu_reset_hold !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_reload: got %0d writes first %h hold %b required 1 %h 0",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '0, cpu_reset_hold, exp_q[0]);
    end
  endtask

  task automatic test_random();
    int base, len;
    for (int it = 0; it < 8; it++) begin
      len = $urandom_range(1, 6);
      random_stim(4 * len);
      model_load(len);
      obs_q.delete();
      base = done_cnt;
      start_load(len);
      send_stream(0, 4 * len, 2);
      wait_done(base, 20);
      checks++;
      if (obs_q.size() !== exp_q.size() || done_cnt - base !== 1) begin
        fails++;
        $display("FAIL random[%0d]_count: got %0d writes %0d dones required %0d 1",
                 it, obs_q.size(), done_cnt - base, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL random[%0d]_write[%0d]: got %h required %h", it, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_full_depth();
    int base, bad;
    random_stim(4 * DEPTH);
    model_load(DEPTH);
    obs_q.delete();
    base = done_cnt;
    start_load(DEPTH);
    send_stream(0, 4 * DEPTH, 0);
    wait_done(base, 20);
    checks++;
    if (obs_q.size() !== DEPTH || done_cnt - base !== 1) begin
      fails++;
      $display("FAIL full_depth_count: got %0d writes %0d dones required %0d 1",
               obs_q.size(), done_cnt - base, DEPTH);
    end
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      if (obs_q[i] !== exp_q[i]) bad++;
    end
    checks++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL full_depth_words: got %0d wrong words required 0", bad);
    end
    checks++;
    if (obs_q.size() > 0 && obs_q[obs_q.size()-1][W-1:32] !== 9'(DEPTH - 1)) begin
      fails++;
      $display("FAIL full_depth_last_addr: got %0d required %0d",
               obs_q[obs_q.size()-1][W-1:32], DEPTH - 1);
    end
  endtask

  initial begin
    test_reset();
    test_vector();
    test_zero_len();
    test_too_long();
    test_gaps();
    test_ignore_start();
    test_reset_mid();
    test_random();
    test_full_depth();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
